rd_drain_arb: RTL
=================

RD_DRAIN_ARB -- requirements
Module: rd_drain_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO word width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of consumers (2..8).
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum words per grant (1..15).
REQ-004 SHALL have port rclk  in  1  read-domain clock.
REQ-005 SHALL have port rrst_n  in  1  reset; rrst_n is asynchronous, active-low, and rclk is the clock.
REQ-006 SHALL have port r_empty  in  1  FIFO empty flag, registered in the rclk domain.
REQ-007 SHALL have port r_data  in  DATA_WIDTH  FIFO memory read data at the current read address, valid whenever r_empty=0.
REQ-008 SHALL have port r_inc  out  1  FIFO pop strobe, combinational.
REQ-009 SHALL have port req  in  NUM_REQ  per-consumer read request, level.
REQ-010 SHALL have port grant  out  NUM_REQ  one-hot registered grant.
REQ-011 SHALL have port out_valid  out  1  output word valid.
REQ-012 SHALL have port out_ready  in  1  downstream accept.
REQ-013 SHALL have port out_data  out  DATA_WIDTH  delivered word.
REQ-014 SHALL have port out_id  out  $clog2(NUM_REQ)  index of the consumer owning out_data.

Function
REQ-015 SHALL implement FSM states IDLE and XFER.
REQ-016 In IDLE with r_empty=0 and req!=0, SHALL select the winner round-robin, starting at rr_ptr; register the one-hot grant and gid; clear burst_cnt; enter XFER next cycle.
REQ-017 In IDLE with r_empty=1 or req=0, SHALL keep grant=0 and stay in IDLE.
REQ-018 SHALL assert r_inc = (state==XFER) & ~r_empty & req[gid] & (~out_valid | out_ready).
REQ-019 On r_inc, SHALL register out_data<=r_data, out_id<=gid, out_valid<=1, and burst_cnt+=1.
REQ-020 Without r_inc, SHALL clear out_valid when out_ready=1 and otherwise hold out_valid, out_data and out_id stable.
REQ-021 When a pop and out_ready coincide, SHALL overwrite the output register and keep out_valid=1, with zero bubble.
REQ-022 SHALL leave XFER for IDLE, clearing grant, when a pop occurs with burst_cnt==BURST_MAX-1.
REQ-023 SHALL also leave XFER for IDLE, without a pop, when req[gid]=0 or r_empty=1.
REQ-024 On each XFER exit, SHALL set rr_ptr to (gid+1) mod NUM_REQ, with wrap-around.
REQ-025 SHALL add no latency beyond the output register: a word is visible on out_* one cycle after its pop.
REQ-026 SHALL size burst_cnt as $clog2(BURST_MAX+1) bits, never exceed BURST_MAX, and apply no arithmetic wrap.
REQ-027 SHALL never assert r_inc while r_empty=1 or while grant=0.

Reset
REQ-028 On rrst_n=0, SHALL immediately set state=IDLE, grant=0, out_valid=0, out_data=0, out_id=0, burst_cnt=0 and rr_ptr=0, and hold r_inc=0.
REQ-029 A reset during XFER SHALL discard the word held in the output register; no pop occurs during reset.

Configuration
REQ-030 With macro RD_DRAIN_ARB_STATS_EN defined, SHALL add output stat_words [15:0], which counts pops and saturates at 16'hFFFF.
REQ-031 With RD_DRAIN_ARB_STATS_EN defined, SHALL also add output stat_stalls [15:0], which counts XFER cycles where r_empty=0, req[gid]=1, out_valid=1 and out_ready=0, and saturates.
REQ-032 With RD_DRAIN_ARB_STATS_EN defined, SHALL reset both counters to 0.
REQ-033 With RD_DRAIN_ARB_STATS_EN undefined, SHALL omit the ports and counters, with no other behaviour change.

Structure
REQ-034 SHALL place the FSM state typedef (IDLE, XFER) and the default constants for DATA_WIDTH, NUM_REQ and BURST_MAX in package rd_drain_arb_pkg.
REQ-035 SHALL implement the round-robin winner selection as the combinational sub-module rr_pick (inputs req and rr_ptr; outputs one-hot and index).

Verification
REQ-036 Scenario: with NUM_REQ=4, BURST_MAX=4, req=4'b0001, 6 words in the FIFO and out_ready=1 -> 4 pops, IDLE, re-grant to 0, 2 pops, exit on empty; out_id=0 for all words.
REQ-037 Scenario: with req=4'b1111 held, rr_ptr=0 and 16 words -> bursts granted in order 0,1,2,3, each 4 words, data order preserved.
REQ-038 Scenario: with out_ready=0 for 5 cycles mid-burst -> r_inc=0 and out_data stable; on release, one pop per cycle, no loss or duplication.
REQ-039 Scenario: req[gid] drops after 2 pops -> exit XFER with no further pop, and rr_ptr=gid+1.
REQ-040 Scenario: gid=3 burst ends -> rr_ptr wraps to 0; with req=4'b1001 the next grant=4'b0001.
REQ-041 Scenario: rrst_n pulsed low mid-burst -> all outputs 0 within the same cycle; r_inc=0; FIFO pointer not advanced; with RD_DRAIN_ARB_STATS_EN defined, stat_words=0.

Source files
------------

// File: rtl/rd_drain_arb_pkg.sv
// rd_drain_arb_pkg
//   Shared types and default constants for the read-side drain arbiter.
//   Contents:
//     state_e           - arbiter FSM state (IDLE, XFER)
//     DEF_DATA_WIDTH    - default FIFO word width
//     DEF_NUM_REQ       - default number of consumers
//     DEF_BURST_MAX     - default maximum words per grant
//     idx_w()           - index width for a consumer count
package rd_drain_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_MAX  = 4;

    // Consumer index width; NUM_REQ is at least 2 so this is never 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_drain_arb_if.sv
// rd_drain_arb_if
//   Bundles the FIFO read port, the consumer request/grant vector and the
//   delivered-word output port of rd_drain_arb.
//   Signals:
//     r_empty   - FIFO empty flag (rclk domain)
//     r_data    - FIFO data at the current read address
//     r_inc     - FIFO pop strobe (combinational, from arbiter)
//     req       - per-consumer level request
//     grant     - one-hot registered grant
//     out_valid / out_ready / out_data / out_id - delivered word handshake
//   Modports:
//     master - the arbiter side
//     slave  - the FIFO / consumer environment side
interface rd_drain_arb_if
    import rd_drain_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) ();
    localparam int IDW = idx_w(NUM_REQ);

    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_inc;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    grant;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDW-1:0]        out_id;

    modport master (
        input  r_empty, r_data, req, out_ready,
        output r_inc, grant, out_valid, out_data, out_id
    );

    modport slave (
        output r_empty, r_data, req, out_ready,
        input  r_inc, grant, out_valid, out_data, out_id
    );

endinterface

// File: rtl/rd_drain_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans req_i starting at ptr_i and
//   wrapping at NUM_REQ; the first set bit wins.
//   Ports:
//     req_i     in  NUM_REQ  request vector
//     ptr_i     in  IDW      highest-priority index
//     gnt_oh_o  out NUM_REQ  one-hot winner (0 when no request)
//     gnt_idx_o out IDW      winner index (0 when no request)
//     gnt_vld_o out 1        some request present
module rr_pick
    import rd_drain_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]     gnt_idx_o,
    output logic               gnt_vld_o
);

    always_comb begin
        int c;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        c         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap instead of '%' so non-power-of-two counts stay cheap.
            c = int'(ptr_i) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!gnt_vld_o && req_i[c]) begin
                gnt_vld_o   = 1'b1;
                gnt_oh_o[c] = 1'b1;
                gnt_idx_o   = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/rd_drain_arb.sv
// rd_drain_arb
//   Drains a FIFO read port into a single registered output stage, handing
//   bursts of up to BURST_MAX words to consumers chosen round-robin.
//   Ports:
//     rclk        in   read-domain clock
//     rrst_n      in   asynchronous active-low reset
//     bus         if   rd_drain_arb_if.master (FIFO read, req/grant, output)
//     stat_words  out  [15:0] saturating pop count      (RD_DRAIN_ARB_STATS_EN)
//     stat_stalls out  [15:0] saturating stall count    (RD_DRAIN_ARB_STATS_EN)
//   Build option: define RD_DRAIN_ARB_STATS_EN to add the two counters.
module rd_drain_arb #(
    parameter int DATA_WIDTH = rd_drain_arb_pkg::DEF_DATA_WIDTH,
    parameter int NUM_REQ    = rd_drain_arb_pkg::DEF_NUM_REQ,
    parameter int BURST_MAX  = rd_drain_arb_pkg::DEF_BURST_MAX
) (
    input  logic              rclk,
    input  logic              rrst_n,
`ifdef RD_DRAIN_ARB_STATS_EN
    output logic [15:0]       stat_words,
    output logic [15:0]       stat_stalls,
`endif
    rd_drain_arb_if.master    bus
);
    import rd_drain_arb_pkg::*;

    localparam int IDW = idx_w(NUM_REQ);
    localparam int CW  = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]  LAST    = CW'(BURST_MAX - 1);
    localparam logic [IDW-1:0] TOP_IDX = IDW'(NUM_REQ - 1);

    state_e                state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IDW-1:0]        gid_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [CW-1:0]         burst_cnt_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [IDW-1:0]        out_id_q;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_vld;
    logic                  pop;
    logic                  owner_req;
    logic [IDW-1:0]        rr_ptr_d;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req_i     (bus.req),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    assign owner_req = bus.req[gid_q];

    // The output stage can take a word when empty or being drained this cycle.
    assign pop = (state_q == XFER) & ~bus.r_empty & owner_req
               & (~out_valid_q | bus.out_ready);

    assign rr_ptr_d = (gid_q == TOP_IDX) ? '0 : gid_q + 1'b1;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gid_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.r_empty && pick_vld) begin
                        grant_q     <= pick_oh;
                        gid_q       <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        // Final pop of the burst also ends the grant, so the
                        // counter peaks at BURST_MAX and never wraps.
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        if (burst_cnt_q == LAST) begin
                            state_q  <= IDLE;
                            grant_q  <= '0;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else if (!owner_req || bus.r_empty) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Single output register: a pop overwrites it even while the
            // previous word is being accepted, so back-to-back has no bubble.
            if (pop) begin
                out_data_q  <= bus.r_data;
                out_id_q    <= gid_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.r_inc     = pop;
    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

`ifdef RD_DRAIN_ARB_STATS_EN
    logic [15:0] stat_words_q;
    logic [15:0] stat_stalls_q;
    logic        stall;

    // Owner has data waiting but the output stage is full and not draining.
    assign stall = (state_q == XFER) & ~bus.r_empty & owner_req
                 & out_valid_q & ~bus.out_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (pop && stat_words_q != 16'hFFFF)
                stat_words_q <= stat_words_q + 16'd1;
            if (stall && stat_stalls_q != 16'hFFFF)
                stat_stalls_q <= stat_stalls_q + 16'd1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule
